water_dispenser_multi: RTL
==========================

// Module: water_dispenser_multi
// PURPOSE
//  Parametrised successor of the single-outlet water dispenser: keypad entry of an amount in ml (switch digits + add/ok/cancel),
//  routed to one of OUTLET_COUNT valves, timed at CYCLES_PER_ML clock cycles per ml. Tracks the tank level, refuses orders it
//  cannot fill, and supports refill. Sits between the board switch/button inputs and the valve drivers / 7-seg display logic.
// PARAMETERS
//  DIGIT_COUNT       4      max decimal digits accepted per order (1..9)
//  OUTLET_COUNT      2      number of valves/outlets (>=1)
//  CYCLES_PER_ML     5      clock cycles per dispensed ml (>=1)
//  TANK_CAPACITY_ML  20000  tank level after reset/refill (<2^32)
// PORTS
//  clock             in   1      system clock, rising edge
//  reset             in   1      asynchronous, active-low (0 = reset)
//  switches          in   10     digit switches, bit i = digit i, active-high
//  button_add        in   1      append lowest active digit, active-low
//  button_ok         in   1      start dispensing, active-low
//  button_cancel     in   1      clear entry / abort dispense, active-low
//  button_outlet     in   1      select next outlet, active-low
//  button_refill     in   1      restore tank to capacity, active-low
//  total_amount_in_ml out 32     amount entered (held during dispense)
//  dispensed_ml      out 32      ml delivered in current/last order
//  selected_outlet   out clog2(OUTLET_COUNT) (min 1)  current outlet index
//  valves            out OUTLET_COUNT  one-hot valve enable, all 0 when idle
//  busy              out 1      1 while in DISPENSING
//  tank_level_ml     out 32     remaining water
//  insufficient      out 1      1-cycle pulse: OK refused (amount > tank level)
// BEHAVIOUR
//  - Reset (async, reset=0): state ENTRY; total, digit count, dispensed_ml, selected_outlet, valves, busy, insufficient = 0;
//    tank_level_ml = TANK_CAPACITY_ML. Synchronizer/edge registers reset to "released" (1).
//  - Inputs: all buttons and switches pass a 2-FF synchronizer. A press = synchronized 1->0 transition; its action commits on
//    the 3rd rising edge after the input is first sampled low. One action per press; holding does not repeat. Releases ignored.
//  - Same-cycle presses priority: cancel > ok > add > outlet > refill; lower-priority presses in that cycle are dropped.
//  - ENTRY state:
//    add: if no switch set or digit count == DIGIT_COUNT -> ignored; else total = total*10 + lowest set switch index,
//         digit count +1 (leading zeros count as digits).
//    cancel: total = 0, digit count = 0; dispensed_ml unchanged.
//    outlet: selected_outlet = (selected_outlet+1) mod OUTLET_COUNT (wrap).
//    refill: tank_level_ml = TANK_CAPACITY_ML.
//    ok: total == 0 -> ignored (no state change); total > tank_level_ml -> insufficient pulses 1 cycle, entry kept;
//        else -> DISPENSING next edge: busy=1, valves[selected_outlet]=1, dispensed_ml=0, cycle counter=0.
//  - DISPENSING state:
//    cycle counter counts 0..CYCLES_PER_ML-1; on wrap dispensed_ml +1 and tank_level_ml -1 (same edge).
//    When dispensed_ml reaches total (edge of last increment, i.e. total*CYCLES_PER_ML cycles after entry): next edge
//    -> ENTRY, valves=0, busy=0, total=0, digit count=0; dispensed_ml holds final value.
//    cancel: abort on commit edge -> ENTRY, valves=0, total/digits cleared; partial ml already counted stay deducted from tank.
//    add/ok/outlet/refill: ignored and not queued; switch changes have no effect.
//  - tank_level_ml never underflows (OK check guarantees it); total never exceeds 10^DIGIT_COUNT-1.
//  - Reset asserted mid-dispense: valves drop immediately (async), all state returns to reset values.
// TESTING (CYCLES_PER_ML=1, OUTLET_COUNT=2, TANK_CAPACITY_ML=2000)
//  1 add digits 1,2,9,0 then 6,4 -> total 1290 (5th/6th ignored); cancel -> total 0, digit count 0.
//  2 switches 8,3,6 held, add -> total 3; switches 9,5,0 held, add -> total 30; add with no switch -> unchanged.
//  3 enter 0,0 then ok -> stays ENTRY, busy 0, valves 0; outlet press x3 -> selected_outlet 0->1->0->1.
//  4 outlet 1, enter 640, ok -> valves=2'b10 for 640 cycles, dispensed_ml 640, tank 1360; cancel mid-way (e.g. at 200 ml)
//    in a rerun -> valves 0 same edge, tank 1800, total 0.
//  5 tank 1360, enter 1380, ok -> insufficient 1-cycle pulse, no dispense; refill, ok -> dispense 1380, tank 620;
//    add/ok/outlet presses during dispense -> no effect on valves, total or selected_outlet.
//  6 assert reset mid-dispense -> valves 0 immediately, tank 2000, outputs at reset values; simultaneous ok+cancel -> cancel wins.

Source files
------------

// File: rtl/water_dispenser_multi_if.sv
// Board-side bundle for the multi-outlet dispenser: switch/button inputs and
// valve/display outputs. The controller uses the slave view, the stimulus side the master view.
interface water_dispenser_multi_if #(
  parameter int OUTLET_COUNT = 2
);
  localparam int SEL_W = (OUTLET_COUNT > 1) ? $clog2(OUTLET_COUNT) : 1;

  logic [9:0]              switches;
  logic                    button_add;
  logic                    button_ok;
  logic                    button_cancel;
  logic                    button_outlet;
  logic                    button_refill;
  logic [31:0]             total_amount_in_ml;
  logic [31:0]             dispensed_ml;
  logic [SEL_W-1:0]        selected_outlet;
  logic [OUTLET_COUNT-1:0] valves;
  logic                    busy;
  logic [31:0]             tank_level_ml;
  logic                    insufficient;

  modport master (
    output switches, button_add, button_ok, button_cancel, button_outlet, button_refill,
    input  total_amount_in_ml, dispensed_ml, selected_outlet, valves, busy,
           tank_level_ml, insufficient
  );

  modport slave (
    input  switches, button_add, button_ok, button_cancel, button_outlet, button_refill,
    output total_amount_in_ml, dispensed_ml, selected_outlet, valves, busy,
           tank_level_ml, insufficient
  );
endinterface

// File: rtl/water_dispenser_multi.sv
// Keypad-driven water dispenser with several outlets and tank tracking.
// Buttons are synchronized and edge-detected; one action per press, cancel having top priority.
module water_dispenser_multi #(
  parameter int DIGIT_COUNT      = 4,
  parameter int OUTLET_COUNT     = 2,
  parameter int CYCLES_PER_ML    = 5,
  parameter int TANK_CAPACITY_ML = 20000
) (
  input logic                   clock,
  input logic                   reset,
  water_dispenser_multi_if.slave bus
);
  localparam int SEL_W = (OUTLET_COUNT > 1) ? $clog2(OUTLET_COUNT) : 1;
  localparam int CNT_W = (CYCLES_PER_ML > 1) ? $clog2(CYCLES_PER_ML) : 1;
  localparam logic [31:0] CAP = 32'(TANK_CAPACITY_ML);

  typedef enum logic {ENTRY, DISPENSING} state_t;

  // Button vector order: add, ok, cancel, outlet, refill (bit 0..4).
  logic [4:0] btn_raw, btn_s1, btn_s2, btn_s3, press;
  logic [9:0] sw_s1, sw_s2;

  assign btn_raw = {bus.button_refill, bus.button_outlet, bus.button_cancel,
                    bus.button_ok, bus.button_add};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_s1 <= '1;
      btn_s2 <= '1;
      btn_s3 <= '1;
      sw_s1  <= '1;
      sw_s2  <= '1;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
      sw_s1  <= bus.switches;
      sw_s2  <= sw_s1;
    end
  end

  // A press is the synchronized 1->0 step; it commits on the following edge.
  assign press = btn_s3 & ~btn_s2;

  logic do_add, do_ok, do_cancel, do_outlet, do_refill;
  assign do_cancel = press[2];
  assign do_ok     = press[1] & ~press[2];
  assign do_add    = press[0] & ~|press[2:1];
  assign do_outlet = press[3] & ~|press[2:0];
  assign do_refill = press[4] & ~|press[3:0];

  logic [3:0] digit;
  always_comb begin
    digit = 4'd0;
    for (int i = 9; i >= 0; i--)
      if (sw_s2[i]) digit = 4'(i);
  end

  state_t                  state;
  logic [31:0]             total, dispensed, tank;
  logic [3:0]              digits;
  logic [SEL_W-1:0]        sel;
  logic [OUTLET_COUNT-1:0] valves;
  logic [CNT_W-1:0]        cyc;
  logic                    busy, insufficient;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ENTRY;
      total        <= '0;
      digits       <= '0;
      dispensed    <= '0;
      sel          <= '0;
      valves       <= '0;
      busy         <= 1'b0;
      insufficient <= 1'b0;
      tank         <= CAP;
      cyc          <= '0;
    end else begin
      insufficient <= 1'b0;
      case (state)
        ENTRY: begin
          if (do_cancel) begin
            total  <= '0;
            digits <= '0;
          end else if (do_ok) begin
            if (total == 32'd0) begin
              // empty order: nothing to do
            end else if (total > tank) begin
              insufficient <= 1'b1;
            end else begin
              state     <= DISPENSING;
              busy      <= 1'b1;
              valves    <= OUTLET_COUNT'(1) << sel;
              dispensed <= '0;
              cyc       <= '0;
            end
          end else if (do_add) begin
            if (|sw_s2 && digits != 4'(DIGIT_COUNT)) begin
              total  <= total * 32'd10 + {28'd0, digit};
              digits <= digits + 4'd1;
            end
          end else if (do_outlet) begin
            sel <= (sel == SEL_W'(OUTLET_COUNT - 1)) ? '0 : sel + 1'b1;
          end else if (do_refill) begin
            tank <= CAP;
          end
        end
        DISPENSING: begin
          if (do_cancel) begin
            state  <= ENTRY;
            valves <= '0;
            busy   <= 1'b0;
            total  <= '0;
            digits <= '0;
          end else if (cyc == CNT_W'(CYCLES_PER_ML - 1)) begin
            cyc       <= '0;
            dispensed <= dispensed + 32'd1;
            tank      <= tank - 32'd1;
            // The valve closes on the edge that delivers the last ml.
            if (dispensed + 32'd1 == total) begin
              state  <= ENTRY;
              valves <= '0;
              busy   <= 1'b0;
              total  <= '0;
              digits <= '0;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

  assign bus.total_amount_in_ml = total;
  assign bus.dispensed_ml       = dispensed;
  assign bus.selected_outlet    = sel;
  assign bus.valves             = valves;
  assign bus.busy               = busy;
  assign bus.tank_level_ml      = tank;
  assign bus.insufficient       = insufficient;
endmodule
